draw_layer_arbiter: RTL and testbench
=====================================

DRAW_LAYER_ARBITER -- requirements
Module: draw_layer_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_LAYERS, 4, number of object layers, legal range 2..6
- TRANSPARENT_COLOR, 8'hFF, RGB value treated as "no pixel"
- BLANK_FRAMES, 2, number of whole frames blanked per blank request (>=1)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  pixel clock
- resetN  in  1  synchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse on the first pixel of a frame
- layerDrawReq  in  NUM_LAYERS  per-layer draw request; bit 0 = player
- layerRGB  in  NUM_LAYERS*8  per-layer RGB; layer k occupies bits [8k+7:8k]
- BG_RGB  in  8  background colour
- boardersDrawReq  in  1  background border pixel flag
- blankReq  in  1  request to blank the screen
- RGBOut  out  8  arbitrated pixel colour
- layerSel  out  3  winning source: 0..NUM_LAYERS-1 = layer, 6 = blank, 7 = background
- blankActive  out  1  high while in BLANK
- collisionFlags  out  NUM_LAYERS  per-frame collision summary
- collisionValid  out  1  one-cycle pulse when collisionFlags is updated

Function
REQ-003 A layer SHALL qualify only when its layerDrawReq bit is high and its RGB is not TRANSPARENT_COLOR.
REQ-004 Among qualifying layers, the lowest index SHALL win; if no layer qualifies, BG_RGB SHALL win (layerSel = 7).
REQ-005 RGBOut and layerSel SHALL be registered with exactly 1 cycle of latency from the input sample.
REQ-006 The FSM SHALL have three states: DRAW, BLANK_PENDING and BLANK.
REQ-007 In DRAW, a blankReq high SHALL move the FSM to BLANK_PENDING, including when startOfFrame is high in the same cycle.
REQ-008 In BLANK_PENDING, the next startOfFrame SHALL move the FSM to BLANK and load the frame counter with BLANK_FRAMES-1. Output stays arbitrated until that cycle.
REQ-009 In BLANK, RGBOut SHALL be 8'h00 and layerSel SHALL be 6. Each startOfFrame with a nonzero counter SHALL decrement it; a startOfFrame with the counter at 0 SHALL return the FSM to DRAW.
REQ-010 blankReq SHALL be ignored in BLANK_PENDING and BLANK.
REQ-011 Collision accumulator bit 0 SHALL set when layer 0 qualifies and boardersDrawReq is high.
REQ-012 Collision accumulator bit k (k>=1) SHALL set when layer 0 and layer k both qualify in the same cycle.
REQ-013 Accumulator bits SHALL be sticky within a frame; accumulation SHALL be suppressed in BLANK.
REQ-014 On startOfFrame, the following SHALL happen:
- collisionFlags takes the accumulator value from before that cycle;
- collisionValid pulses high for exactly 1 cycle;
- the accumulator restarts with only that cycle's hits, because the startOfFrame pixel belongs to the new frame.
REQ-015 blankActive SHALL be registered and high exactly while the state is BLANK.
REQ-016 A startOfFrame pulse SHALL be processed identically in every state. Back-to-back pulses are legal.

Reset
REQ-017 When resetN is low at a clock edge, the block SHALL set:
- RGBOut = 0, layerSel = 7
- blankActive = 0, collisionFlags = 0, collisionValid = 0
- accumulator = 0, counter = 0, state = DRAW
REQ-018 A reset during BLANK or BLANK_PENDING SHALL abort the blank with no residual effect.

Configuration
REQ-019 With DRAW_ARB_COLLISION_EN defined, REQ-011 to REQ-014 SHALL apply.
REQ-020 Without DRAW_ARB_COLLISION_EN, collisionFlags and collisionValid SHALL be constant 0 and no accumulator logic SHALL be built; arbitration and blanking SHALL be unchanged.

Structure
REQ-021 Package draw_arb_pkg SHALL hold:
- the FSM state enum;
- LAYER_SEL_BLANK = 6 and LAYER_SEL_BG = 7;
- default values for TRANSPARENT_COLOR and BLANK_FRAMES.
REQ-022 The collision accumulator and its frame latch SHALL be the sub-module draw_arb_collision_tracker, instantiated under DRAW_ARB_COLLISION_EN.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Layers 1 and 3 requesting with RGB 8'h1C and 8'hE0, layer 0 idle -> next cycle RGBOut = 8'h1C, layerSel = 1.
- Layer 0 requesting with RGB 8'hFF, BG_RGB = 8'h03 -> RGBOut = 8'h03, layerSel = 7.
- blankReq pulse mid-frame with BLANK_FRAMES = 2 -> output unchanged until next startOfFrame, then 8'h00 and layerSel = 6 for exactly 2 frames, then DRAW.
- Layer 0 and layer 2 overlap for one pixel in frame N -> at the frame N+1 startOfFrame, collisionFlags = 4'b0100 and collisionValid high for 1 cycle; at frame N+2, flags = 0.
- Overlap on the startOfFrame pixel itself -> that hit is reported one frame later, not in the current latch.
- resetN low for 1 cycle during BLANK -> next cycle blankActive = 0, layerSel = 7, and arbitration resumes.

Source files
------------

// File: rtl/draw_arb_pkg.sv
// -----------------------------------------------------------------------------
// draw_arb_pkg
// Shared types and constants for the draw layer arbiter:
//   arb_state_t            - blanking FSM states (DRAW, BLANK_PENDING, BLANK)
//   LAYER_SEL_BLANK / _BG  - layerSel codes for the blank and background sources
//   DEF_TRANSPARENT_COLOR  - default "no pixel" RGB value
//   DEF_BLANK_FRAMES       - default number of frames blanked per request
// -----------------------------------------------------------------------------
package draw_arb_pkg;

    typedef enum logic [1:0] {
        ST_DRAW          = 2'd0,
        ST_BLANK_PENDING = 2'd1,
        ST_BLANK         = 2'd2
    } arb_state_t;

    localparam logic [2:0] LAYER_SEL_BLANK = 3'd6;
    localparam logic [2:0] LAYER_SEL_BG    = 3'd7;

    localparam logic [7:0] DEF_TRANSPARENT_COLOR = 8'hFF;
    localparam int         DEF_BLANK_FRAMES      = 2;

    // Width of a down-counter that must hold values 0..frames-1.
    function automatic int cnt_width(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

endpackage

// File: rtl/draw_layer_arbiter_if.sv
// -----------------------------------------------------------------------------
// draw_layer_arbiter_if
// Pixel-side bundle of the draw layer arbiter.
//   master modport: the pixel source (drives frame/layer/background/blank
//                   inputs, receives the arbitrated pixel and collision status)
//   slave modport : the arbiter itself
// Signals:
//   startOfFrame, layerDrawReq[NUM_LAYERS], layerRGB[NUM_LAYERS*8], BG_RGB[8],
//   boardersDrawReq, blankReq                              (source -> arbiter)
//   RGBOut[8], layerSel[3], blankActive, collisionFlags[NUM_LAYERS],
//   collisionValid                                         (arbiter -> source)
// -----------------------------------------------------------------------------
interface draw_layer_arbiter_if #(
    parameter int NUM_LAYERS = 4
);
    logic                    startOfFrame;
    logic [NUM_LAYERS-1:0]   layerDrawReq;
    logic [NUM_LAYERS*8-1:0] layerRGB;
    logic [7:0]              BG_RGB;
    logic                    boardersDrawReq;
    logic                    blankReq;

    logic [7:0]              RGBOut;
    logic [2:0]              layerSel;
    logic                    blankActive;
    logic [NUM_LAYERS-1:0]   collisionFlags;
    logic                    collisionValid;

    modport master (
        output startOfFrame, layerDrawReq, layerRGB, BG_RGB, boardersDrawReq, blankReq,
        input  RGBOut, layerSel, blankActive, collisionFlags, collisionValid
    );

    modport slave (
        input  startOfFrame, layerDrawReq, layerRGB, BG_RGB, boardersDrawReq, blankReq,
        output RGBOut, layerSel, blankActive, collisionFlags, collisionValid
    );
endinterface

// File: rtl/draw_arb_collision_tracker.sv
// -----------------------------------------------------------------------------
// draw_arb_collision_tracker
// Per-frame collision accumulator plus its frame latch.
//   bit 0 : player (layer 0) drawn on a border pixel
//   bit k : player and layer k both drawn on the same pixel
// Ports:
//   clk, resetN       - clock, synchronous active-low reset
//   start_of_frame    - first pixel of a frame; latches and restarts the sum
//   accum_en          - low while the screen is blanked
//   layer_qual        - per-layer "draws a visible pixel" this cycle
//   border_req        - current pixel is a border pixel
//   collision_flags   - accumulator value of the frame just finished
//   collision_valid   - one-cycle pulse when collision_flags is updated
// -----------------------------------------------------------------------------
module draw_arb_collision_tracker #(
    parameter int NUM_LAYERS = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start_of_frame,
    input  logic                  accum_en,
    input  logic [NUM_LAYERS-1:0] layer_qual,
    input  logic                  border_req,
    output logic [NUM_LAYERS-1:0] collision_flags,
    output logic                  collision_valid
);

    logic [NUM_LAYERS-1:0] hit_raw;
    logic [NUM_LAYERS-1:0] hit_next;
    logic [NUM_LAYERS-1:0] accum_reg;
    logic [NUM_LAYERS-1:0] flags_reg;
    logic                  valid_reg;

    assign hit_raw[0] = layer_qual[0] & border_req;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_LAYERS; gi++) begin : g_hit
            assign hit_raw[gi] = layer_qual[0] & layer_qual[gi];
        end
    endgenerate

    assign hit_next = accum_en ? hit_raw : '0;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            accum_reg <= '0;
            flags_reg <= '0;
            valid_reg <= 1'b0;
        end else if (start_of_frame) begin
            // The start-of-frame pixel already belongs to the new frame, so
            // its hits seed the fresh accumulator instead of the latched value.
            flags_reg <= accum_reg;
            valid_reg <= 1'b1;
            accum_reg <= hit_next;
        end else begin
            valid_reg <= 1'b0;
            accum_reg <= accum_reg | hit_next;
        end
    end

    assign collision_flags = flags_reg;
    assign collision_valid = valid_reg;

endmodule

// File: rtl/draw_layer_arbiter.sv
// -----------------------------------------------------------------------------
// draw_layer_arbiter
// Fixed-priority pixel mixer for NUM_LAYERS object layers over a background,
// with a frame-aligned screen-blank sequence and optional collision reporting.
// Ports:
//   clk     - pixel clock
//   resetN  - synchronous active-low reset
//   bus     - draw_layer_arbiter_if.slave (pixel inputs, RGBOut, layerSel,
//             blankActive, collisionFlags, collisionValid)
// Parameters: NUM_LAYERS (2..6), TRANSPARENT_COLOR, BLANK_FRAMES (>=1)
// Build option: define DRAW_ARB_COLLISION_EN to build the collision tracker;
//               otherwise collisionFlags/collisionValid are tied to 0.
// -----------------------------------------------------------------------------
module draw_layer_arbiter
    import draw_arb_pkg::*;
#(
    parameter int         NUM_LAYERS        = 4,
    parameter logic [7:0] TRANSPARENT_COLOR = DEF_TRANSPARENT_COLOR,
    parameter int         BLANK_FRAMES      = DEF_BLANK_FRAMES
) (
    input  logic                 clk,
    input  logic                 resetN,
    draw_layer_arbiter_if.slave  bus
);

    localparam int CNT_W = cnt_width(BLANK_FRAMES);

    logic [NUM_LAYERS-1:0] layer_qual;
    logic [7:0]            win_rgb;
    logic [2:0]            win_sel;
    logic                  blank_next;

    arb_state_t            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [7:0]            rgb_out_reg;
    logic [2:0]            layer_sel_reg;
    logic                  blank_active_reg;

    // A layer only competes when it asks to draw and its pixel is visible.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_qual
            assign layer_qual[gi] = bus.layerDrawReq[gi] &&
                                    (bus.layerRGB[8*gi +: 8] != TRANSPARENT_COLOR);
        end
    endgenerate

    // Walk from the highest index down so the lowest qualifying layer wins.
    always_comb begin
        win_sel = LAYER_SEL_BG;
        win_rgb = bus.BG_RGB;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (layer_qual[k]) begin
                win_sel = 3'(k);
                win_rgb = bus.layerRGB[8*k +: 8];
            end
        end
    end

    // State after this edge is BLANK: the registered pixel and blankActive
    // switch together with the state so that blankActive tracks BLANK exactly.
    always_comb begin
        blank_next = 1'b0;
        case (state_reg)
            ST_BLANK_PENDING: blank_next = bus.startOfFrame;
            ST_BLANK:         blank_next = !(bus.startOfFrame && (cnt_reg == '0));
            default:          blank_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg        <= ST_DRAW;
            cnt_reg          <= '0;
            rgb_out_reg      <= 8'h00;
            layer_sel_reg    <= LAYER_SEL_BG;
            blank_active_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_DRAW: begin
                    if (bus.blankReq) begin
                        state_reg <= ST_BLANK_PENDING;
                    end
                end
                ST_BLANK_PENDING: begin
                    if (bus.startOfFrame) begin
                        state_reg <= ST_BLANK;
                        cnt_reg   <= CNT_W'(BLANK_FRAMES - 1);
                    end
                end
                ST_BLANK: begin
                    if (bus.startOfFrame) begin
                        if (cnt_reg == '0) begin
                            state_reg <= ST_DRAW;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_DRAW;
            endcase

            blank_active_reg <= blank_next;
            if (blank_next) begin
                rgb_out_reg   <= 8'h00;
                layer_sel_reg <= LAYER_SEL_BLANK;
            end else begin
                rgb_out_reg   <= win_rgb;
                layer_sel_reg <= win_sel;
            end
        end
    end

    assign bus.RGBOut      = rgb_out_reg;
    assign bus.layerSel    = layer_sel_reg;
    assign bus.blankActive = blank_active_reg;

`ifdef DRAW_ARB_COLLISION_EN
    draw_arb_collision_tracker #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_collision (
        .clk             (clk),
        .resetN          (resetN),
        .start_of_frame  (bus.startOfFrame),
        .accum_en        (state_reg != ST_BLANK),
        .layer_qual      (layer_qual),
        .border_req      (bus.boardersDrawReq),
        .collision_flags (bus.collisionFlags),
        .collision_valid (bus.collisionValid)
    );
`else
    logic unused_border;
    assign unused_border      = bus.boardersDrawReq;
    assign bus.collisionFlags = '0;
    assign bus.collisionValid = 1'b0;
`endif

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_draw_layer_arbiter
// Directed bench: a table of single-pixel arbitration vectors, followed by
// hand-written blank, reset-abort and collision sequences. Inputs change on
// the falling edge; outputs are sampled on the falling edge after the next
// rising edge.
// -----------------------------------------------------------------------------
module tb_draw_layer_arbiter;
    import draw_arb_pkg::*;

`ifdef DRAW_ARB_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic clk;
    logic resetN;

    draw_layer_arbiter_if #(.NUM_LAYERS(4)) bus ();

    draw_layer_arbiter #(
        .NUM_LAYERS        (4),
        .TRANSPARENT_COLOR (8'hFF),
        .BLANK_FRAMES      (2)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] rgb;
        logic [7:0]  bg;
        logic [7:0]  exp_rgb;
        logic [2:0]  exp_sel;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_pix(input string name, input logic [7:0] rgb,
                             input logic [2:0] sel, input logic blank);
        check({name, ".rgb"},   32'(bus.RGBOut),      32'(rgb));
        check({name, ".sel"},   32'(bus.layerSel),    32'(sel));
        check({name, ".blank"}, 32'(bus.blankActive), 32'(blank));
    endtask

    task automatic check_coll(input string name, input logic [3:0] flags, input logic valid);
        check({name, ".flags"}, 32'(bus.collisionFlags), COLL ? 32'(flags) : 32'd0);
        check({name, ".valid"}, 32'(bus.collisionValid), COLL ? 32'(valid) : 32'd0);
    endtask

    task automatic sof_step();
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        step();
        resetN = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // rgb packing: {layer3, layer2, layer1, layer0}
        vecs[0] = '{4'b1010, {8'hE0, 8'h00, 8'h1C, 8'h00}, 8'h00, 8'h1C, 3'd1};
        vecs[1] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'hFF}, 8'h03, 8'h03, 3'd7};
        vecs[2] = '{4'b0000, {8'h44, 8'h33, 8'h22, 8'h11}, 8'h55, 8'h55, 3'd7};
        vecs[3] = '{4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 8'h55, 8'h11, 3'd0};
        vecs[4] = '{4'b1110, {8'h44, 8'h33, 8'hFF, 8'h11}, 8'h55, 8'h33, 3'd2};
        vecs[5] = '{4'b1000, {8'hFF, 8'h33, 8'h22, 8'h11}, 8'hAA, 8'hAA, 3'd7};
        vecs[6] = '{4'b0001, {8'h44, 8'h33, 8'h22, 8'h00}, 8'hAA, 8'h00, 3'd0};

        resetN              = 1'b0;
        bus.startOfFrame    = 1'b0;
        bus.layerDrawReq    = 4'b1111;
        bus.layerRGB        = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.BG_RGB          = 8'h5A;
        bus.boardersDrawReq = 1'b1;
        bus.blankReq        = 1'b0;

        // ---- reset state (inputs deliberately active) ----
        @(negedge clk);
        step();
        check_pix("reset", 8'h00, LAYER_SEL_BG, 1'b0);
        check_coll("reset", 4'b0000, 1'b0);
        resetN              = 1'b1;
        bus.boardersDrawReq = 1'b0;

        // ---- arbitration table ----
        for (int i = 0; i < 7; i++) begin
            bus.layerDrawReq = vecs[i].req;
            bus.layerRGB     = vecs[i].rgb;
            bus.BG_RGB       = vecs[i].bg;
            step();
            check_pix($sformatf("vec%0d", i), vecs[i].exp_rgb, vecs[i].exp_sel, 1'b0);
        end

        // ---- blank sequence, BLANK_FRAMES = 2, 4-cycle frames ----
        do_reset();
        bus.layerDrawReq = 4'b0001;
        bus.layerRGB     = {8'h44, 8'h33, 8'h22, 8'h42};
        bus.BG_RGB       = 8'h03;
        step();
        bus.blankReq = 1'b1;
        step();
        bus.blankReq = 1'b0;
        check_pix("pend_hold", 8'h42, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_pix("pend_wait", 8'h42, 3'd0, 1'b0);
        end
        sof_step();
        check_pix("blank_enter", 8'h00, LAYER_SEL_BLANK, 1'b1);
        bus.blankReq = 1'b1;        // must be ignored while blanking
        for (int i = 0; i < 3; i++) begin
            step();
            check_pix("blank_f1", 8'h00, LAYER_SEL_BLANK, 1'b1);
        end
        bus.blankReq = 1'b0;
        sof_step();
        check_pix("blank_f2_sof", 8'h00, LAYER_SEL_BLANK, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_pix("blank_f2", 8'h00, LAYER_SEL_BLANK, 1'b1);
        end
        sof_step();
        check_pix("blank_exit", 8'h42, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        sof_step();
        check_pix("no_reblank", 8'h42, 3'd0, 1'b0);

        // blankReq together with startOfFrame only arms the blank
        bus.blankReq = 1'b1;
        sof_step();
        bus.blankReq = 1'b0;
        check_pix("sof_req_pend", 8'h42, 3'd0, 1'b0);
        step();
        sof_step();
        check_pix("sof_req_blank", 8'h00, LAYER_SEL_BLANK, 1'b1);

        // ---- reset during BLANK aborts it ----
        step();
        do_reset();
        check_pix("rst_blank", 8'h00, LAYER_SEL_BG, 1'b0);
        step();
        check_pix("rst_resume", 8'h42, 3'd0, 1'b0);
        sof_step();
        check_pix("rst_no_resid", 8'h42, 3'd0, 1'b0);

        // ---- collision reporting ----
        do_reset();
        bus.layerDrawReq = 4'b0000;
        bus.layerRGB     = {8'h40, 8'h30, 8'h20, 8'h10};
        sof_step();                                    // frame N
        check_coll("coll_first", 4'b0000, 1'b1);
        step();
        check_coll("coll_pulse1", 4'b0000, 1'b0);
        bus.layerDrawReq = 4'b0101;                    // layers 0 and 2 overlap
        step();
        bus.layerDrawReq = 4'b0000;
        step();
        sof_step();                                    // frame N+1
        check_coll("coll_n1", 4'b0100, 1'b1);
        step();
        check_coll("coll_hold", 4'b0100, 1'b0);
        step();
        sof_step();                                    // frame N+2
        check_coll("coll_n2", 4'b0000, 1'b1);

        bus.layerDrawReq = 4'b0011;                    // overlap on the sof pixel
        sof_step();
        bus.layerDrawReq = 4'b0000;
        check_coll("coll_sof_now", 4'b0000, 1'b1);
        step();
        bus.layerDrawReq    = 4'b0001;                 // player on border
        bus.boardersDrawReq = 1'b1;
        step();
        bus.boardersDrawReq = 1'b0;
        bus.layerRGB        = {8'h40, 8'h30, 8'h20, 8'hFF};
        bus.layerDrawReq    = 4'b1001;                 // transparent player: no hit
        step();
        bus.layerDrawReq    = 4'b0000;
        sof_step();
        check_coll("coll_sof_late", 4'b0011, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
